// File: rtl/status_ctrl_pkg.sv
// Shared types and constants for the CPU status-register controller.
package status_ctrl_pkg;

  localparam int unsigned NUM_STATUS_BITS = 3;
  localparam int unsigned STACK_DEPTH     = 4;

  // Controller phases: idle/arbitrating, saving on interrupt entry, restoring on return.
  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE
  } state_e;

  // Which source owns the status register in the current cycle.
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_DEC  = 2'd2;
  localparam logic [1:0] SRC_IRQ  = 2'd3;

  // Fixed priority: any interrupt pulse, then ALU, then decoder.
  function automatic logic [1:0] pick_src(input logic irq, input logic alu, input logic dec);
    if (irq) begin
      return SRC_IRQ;
    end else if (alu) begin
      return SRC_ALU;
    end else if (dec) begin
      return SRC_DEC;
    end
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/status_stack.sv
// LIFO shadow stack for nested interrupt status save/restore.
// rdata always presents the top entry (stack[sp-1]); push/pop are ignored when full/empty.
module status_stack #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 4,
  parameter int unsigned PtrW  = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW:0]    sp_q;
  logic [PtrW:0]    sp_m1;

  assign full  = (sp_q == (PtrW+1)'(Depth));
  assign empty = (sp_q == '0);
  assign sp_m1 = sp_q - (PtrW+1)'(1);
  assign rdata = mem[sp_m1[PtrW-1:0]];

  // Stack pointer: saturating bookkeeping, never wraps.
  always_ff @(posedge clk) begin
    if (res) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + (PtrW+1)'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_m1;
    end
  end

  // Storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp_q[PtrW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/status_ctrl.sv
// CPU status register owner: fixed-priority arbitration of ALU/decoder writes and
// interrupt save/restore through a shadow stack.
// Optional macro STATUS_CTRL_MASK_EN adds dec_mask for bit-selective decoder writes.
module status_ctrl
  import status_ctrl_pkg::*;
#(
  parameter int unsigned NumStatusBits = NUM_STATUS_BITS,
  parameter int unsigned StackDepth    = STACK_DEPTH,
  parameter int unsigned PtrW          = 2
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     alu_req,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic                     alu_gnt,
  input  logic                     dec_req,
  input  logic [NumStatusBits-1:0] dec_status,
`ifdef STATUS_CTRL_MASK_EN
  input  logic [NumStatusBits-1:0] dec_mask,
`endif
  output logic                     dec_gnt,
  input  logic                     irq_enter,
  input  logic                     irq_return,
  output logic [NumStatusBits-1:0] status,
  output logic                     busy,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     err_ovf,
  output logic                     err_unf
);

  state_e                   state_q;
  logic [NumStatusBits-1:0] status_q;
  logic                     err_ovf_q;
  logic                     err_unf_q;
  logic [1:0]               src;
  logic [NumStatusBits-1:0] dec_wdata;
  logic [NumStatusBits-1:0] stack_rd;

  status_stack #(
    .Width (NumStatusBits),
    .Depth (StackDepth),
    .PtrW  (PtrW)
  ) u_stack (
    .clk   (clk),
    .res   (res),
    .push  (state_q == SAVE),
    .pop   (state_q == RESTORE),
    .wdata (status_q),
    .rdata (stack_rd),
    .full  (stack_full),
    .empty (stack_empty)
  );

  // Arbitration: grants only in IDLE with no interrupt pulse on the bus.
  always_comb begin
    src = SRC_NONE;
    if (state_q == IDLE) begin
      src = pick_src(irq_enter | irq_return, alu_req, dec_req);
    end
    alu_gnt = (src == SRC_ALU);
    dec_gnt = (src == SRC_DEC);
  end

  // Decoder write data: merge under mask when the feature is built in.
  always_comb begin
`ifdef STATUS_CTRL_MASK_EN
    dec_wdata = (status_q & ~dec_mask) | (dec_status & dec_mask);
`else
    dec_wdata = dec_status;
`endif
  end

  // Main FSM: status register, sticky errors and save/restore sequencing.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      status_q  <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          unique case (src)
            SRC_IRQ: begin
              // Return wins over a simultaneous enter.
              if (irq_return) begin
                if (stack_empty) begin
                  err_unf_q <= 1'b1;
                end else begin
                  state_q <= RESTORE;
                end
              end else if (stack_full) begin
                err_ovf_q <= 1'b1;
              end else begin
                state_q <= SAVE;
              end
            end
            SRC_ALU:  status_q <= alu_status;
            SRC_DEC:  status_q <= dec_wdata;
            SRC_NONE: ;
            default:  ;
          endcase
        end
        SAVE: begin
          // Stack captures the old value this cycle; handler starts with clean flags.
          status_q <= '0;
          state_q  <= IDLE;
        end
        RESTORE: begin
          status_q <= stack_rd;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign status  = status_q;
  assign busy    = (state_q != IDLE);
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_status_ctrl.sv
// Scoreboard bench for status_ctrl: directed scenarios plus constrained-random traffic,
// expectations from a queue-based behavioural model.
module tb_status_ctrl;
  import status_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       alu_req = 1'b0;
  logic [2:0] alu_status = '0;
  logic       alu_gnt;
  logic       dec_req = 1'b0;
  logic [2:0] dec_status = '0;
  logic       dec_gnt;
  logic       irq_enter = 1'b0;
  logic       irq_return = 1'b0;
  logic [2:0] status;
  logic       busy, stack_full, stack_empty, err_ovf, err_unf;
`ifdef STATUS_CTRL_MASK_EN
  logic [2:0] dec_mask = '0;
`endif

  always #5 clk = ~clk;

  status_ctrl dut (
    .clk         (clk),
    .res         (res),
    .alu_req     (alu_req),
    .alu_status  (alu_status),
    .alu_gnt     (alu_gnt),
    .dec_req     (dec_req),
    .dec_status  (dec_status),
`ifdef STATUS_CTRL_MASK_EN
    .dec_mask    (dec_mask),
`endif
    .dec_gnt     (dec_gnt),
    .irq_enter   (irq_enter),
    .irq_return  (irq_return),
    .status      (status),
    .busy        (busy),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf)
  );

  typedef struct packed {
    logic       alu_gnt;
    logic       dec_gnt;
    logic [2:0] status;
    logic       busy;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } obs_t;

  obs_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: status value, saved values as a queue, one pending save/restore.
  logic [2:0] m_status = '0;
  logic [2:0] m_stack[$];
  int         m_pending = 0;  // 0 none, 1 save, 2 restore
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_alu_g, m_dec_g;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t e;
      e = sb.pop_front();
      check("alu_gnt", 3'(alu_gnt), 3'(e.alu_gnt));
      check("dec_gnt", 3'(dec_gnt), 3'(e.dec_gnt));
      check("status", status, e.status);
      check("busy", 3'(busy), 3'(e.busy));
      check("stack_full", 3'(stack_full), 3'(e.full));
      check("stack_empty", 3'(stack_empty), 3'(e.empty));
      check("err_ovf", 3'(err_ovf), 3'(e.ovf));
      check("err_unf", 3'(err_unf), 3'(e.unf));
    end
  end

  // One clock cycle of stimulus; records the expected observation and advances the model.
  task automatic step(input logic r, input logic ar, input logic [2:0] ad, input logic dr,
                      input logic [2:0] dd, input logic en, input logic rt,
                      input logic [2:0] mk);
    obs_t       e;
    logic       idle;
    logic [2:0] eff_mask;
    @(posedge clk);
    #1;
    res = r; alu_req = ar; alu_status = ad; dec_req = dr; dec_status = dd;
    irq_enter = en; irq_return = rt;
`ifdef STATUS_CTRL_MASK_EN
    dec_mask = mk;
    eff_mask = mk;
`else
    eff_mask = 3'b111;
`endif
    idle     = (m_pending == 0);
    m_alu_g  = idle && !(en || rt) && ar;
    m_dec_g  = idle && !(en || rt) && !ar && dr;
    e.alu_gnt = m_alu_g;
    e.dec_gnt = m_dec_g;
    e.status  = m_status;
    e.busy    = !idle;
    e.full    = (m_stack.size() == STACK_DEPTH);
    e.empty   = (m_stack.size() == 0);
    e.ovf     = m_ovf;
    e.unf     = m_unf;
    sb.push_back(e);
    if (r) begin
      m_status = '0; m_stack.delete(); m_pending = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (m_pending == 1) begin
      m_stack.push_back(m_status); m_status = '0; m_pending = 0;
    end else if (m_pending == 2) begin
      m_status = m_stack.pop_back(); m_pending = 0;
    end else if (rt) begin
      if (m_stack.size() == 0) m_unf = 1'b1;
      else m_pending = 2;
    end else if (en) begin
      if (m_stack.size() == STACK_DEPTH) m_ovf = 1'b1;
      else m_pending = 1;
    end else if (ar) begin
      m_status = ad;
    end else if (dr) begin
      m_status = (m_status & ~eff_mask) | (dd & eff_mask);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 1'b0, 1'b0, 3'b0);
  endtask

  task automatic alu_write(input logic [2:0] v);
    step(1'b0, 1'b1, v, 1'b0, 3'b0, 1'b0, 1'b0, 3'b0);
  endtask

  initial begin
    logic       ar = 1'b0;
    logic [2:0] ad = '0;
    logic       dr = 1'b0;
    logic [2:0] dd = '0;
    int         waited;

    // Reset held for two cycles, then reset values.
    step(1'b1, 1'b0, 3'b0, 1'b0, 3'b0, 1'b0, 1'b0, 3'b0);
    step(1'b1, 1'b0, 3'b0, 1'b0, 3'b0, 1'b0, 1'b0, 3'b0);
    idle_cycles(1);

    // Arbitration: ALU beats decoder, decoder follows.
    step(1'b0, 1'b1, 3'b101, 1'b1, 3'b010, 1'b0, 1'b0, 3'b111);
    step(1'b0, 1'b0, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 3'b111);
    idle_cycles(1);

    // Save/restore around a handler write.
    alu_write(3'b011);
    step(1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 1'b1, 1'b0, 3'b0);
    idle_cycles(1);
    alu_write(3'b110);
    step(1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 1'b0, 1'b1, 3'b0);
    idle_cycles(2);

    // Overflow then underflow.
    alu_write(3'b000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 1'b1, 1'b0, 3'b0);
      idle_cycles(2);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 1'b0, 1'b1, 3'b0);
      idle_cycles(2);
    end

    // Simultaneous enter+return on an empty stack: return wins (underflow, no save).
    step(1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 1'b1, 1'b1, 3'b0);
    idle_cycles(1);

    // ALU request held across an interrupt entry.
    step(1'b0, 1'b1, 3'b110, 1'b0, 3'b0, 1'b1, 1'b0, 3'b0);
    step(1'b0, 1'b1, 3'b110, 1'b0, 3'b0, 1'b0, 1'b0, 3'b0);
    step(1'b0, 1'b1, 3'b110, 1'b0, 3'b0, 1'b0, 1'b0, 3'b0);
    idle_cycles(1);

    // Masked (or full-width) decoder write.
    alu_write(3'b111);
    step(1'b0, 1'b0, 3'b0, 1'b1, 3'b000, 1'b0, 1'b0, 3'b010);
    idle_cycles(1);

    // Reset mid-operation, then random traffic.
    step(1'b0, 1'b0, 3'b0, 1'b0, 3'b0, 1'b1, 1'b0, 3'b0);
    step(1'b1, 1'b0, 3'b0, 1'b0, 3'b0, 1'b0, 1'b0, 3'b0);
    idle_cycles(1);

    for (int n = 0; n < 3000; n++) begin
      logic en, rt, r;
      if (!ar && $urandom_range(0, 2) == 0) begin ar = 1'b1; ad = 3'($urandom); end
      if (!dr && $urandom_range(0, 2) == 0) begin dr = 1'b1; dd = 3'($urandom); end
      en = 1'b0;
      rt = 1'b0;
      if (m_pending == 0) begin
        case ($urandom_range(0, 9))
          0, 1:    en = 1'b1;
          2:       rt = 1'b1;
          3:       begin en = 1'b1; rt = 1'b1; end
          default: ;
        endcase
      end
      r = ($urandom_range(0, 299) == 0);
      step(r, ar, ad, dr, dd, en, rt, 3'($urandom));
      if (m_alu_g || r) ar = 1'b0;
      if (m_dec_g || r) dr = 1'b0;
    end
    idle_cycles(1);

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
